// File: rtl/gapl_stream_pkg.sv
// Stream constants shared by the receive packer, the stateful processor and the transmit unpacker.
package gapl_stream_pkg;

    localparam int BYTE_WIDTH        = 8;
    localparam int FRAME_COUNT_WIDTH = 16;

    typedef enum logic [0:0] {
        PACK_IDLE = 1'b0,
        PACK_FILL = 1'b1
    } pack_state_t;

endpackage

// File: rtl/stream_output_register.sv
// One-entry valid/ready holding register with a load port.
// A load in the same cycle as a transfer replaces the departing entry.
module stream_output_register #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic [DATA_WIDTH-1:0] data_r;
    logic                  valid_r;

    // Entry storage: load wins over drain, so a full register keeps streaming.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r  <= {DATA_WIDTH{1'b0}};
            valid_r <= 1'b0;
        end else if (load) begin
            data_r  <= load_data;
            valid_r <= 1'b1;
        end else if (valid_r && out_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign out_valid = valid_r;
    assign out_data  = data_r;

endmodule

// File: rtl/byte_stream_packer.sv
// Packs a framed byte stream into REPLICATION_FACTOR-byte words, zero-padding
// the short last word of a frame and counting completed frames.
module byte_stream_packer
    import gapl_stream_pkg::*;
#(
    parameter  int REPLICATION_FACTOR = 3,
    localparam int COUNT_WIDTH        = $clog2(REPLICATION_FACTOR + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 enable,
    input  logic [BYTE_WIDTH-1:0]                in_data,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic                                 in_last,
    output logic [BYTE_WIDTH*REPLICATION_FACTOR-1:0] out_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 out_last,
    output logic [COUNT_WIDTH-1:0]               out_count,
    output logic [FRAME_COUNT_WIDTH-1:0]         frames_done
);

    localparam int WORD_WIDTH = BYTE_WIDTH * REPLICATION_FACTOR;
    localparam int IDX_WIDTH  = (REPLICATION_FACTOR > 1) ? $clog2(REPLICATION_FACTOR) : 1;
    localparam int REG_WIDTH  = WORD_WIDTH + 1 + COUNT_WIDTH;

    pack_state_t                  state_r;
    logic [IDX_WIDTH-1:0]         idx_r;
    logic [WORD_WIDTH-1:0]        acc_r;
    logic [FRAME_COUNT_WIDTH-1:0] frames_done_r;

    logic                  accept_s;
    logic                  complete_s;
    logic                  load_s;
    logic [WORD_WIDTH-1:0] merged_s;
    logic [COUNT_WIDTH-1:0] count_s;
    logic [REG_WIDTH-1:0]  load_word_s;
    logic [REG_WIDTH-1:0]  held_word_s;

    // Reset is folded in so nothing is accepted while the block is held in reset.
    assign in_ready = rst_n & enable & (~out_valid | out_ready);

    // Merge the incoming byte into its lane; an idle packer starts from a clean word.
    always_comb begin
        accept_s   = in_valid & in_ready;
        complete_s = (idx_r == IDX_WIDTH'(REPLICATION_FACTOR - 1)) | in_last;
        load_s     = accept_s & complete_s;
        count_s    = COUNT_WIDTH'(idx_r) + COUNT_WIDTH'(1);
        merged_s   = acc_r;
        case (state_r)
            PACK_IDLE: begin
                merged_s                   = {WORD_WIDTH{1'b0}};
                merged_s[BYTE_WIDTH-1:0]   = in_data;
            end
            PACK_FILL: begin
                merged_s[int'(idx_r)*BYTE_WIDTH +: BYTE_WIDTH] = in_data;
            end
            default: begin
                merged_s = acc_r;
            end
        endcase
        load_word_s = {count_s, in_last, merged_s};
    end

    // Lane index, accumulator, fill state and frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= PACK_IDLE;
            idx_r         <= {IDX_WIDTH{1'b0}};
            acc_r         <= {WORD_WIDTH{1'b0}};
            frames_done_r <= {FRAME_COUNT_WIDTH{1'b0}};
        end else if (accept_s && complete_s) begin
            state_r <= PACK_IDLE;
            idx_r   <= {IDX_WIDTH{1'b0}};
            acc_r   <= {WORD_WIDTH{1'b0}};
            if (in_last) begin
                frames_done_r <= frames_done_r + FRAME_COUNT_WIDTH'(1);
            end else begin
                frames_done_r <= frames_done_r;
            end
        end else if (accept_s) begin
            state_r <= PACK_FILL;
            idx_r   <= idx_r + IDX_WIDTH'(1);
            acc_r   <= merged_s;
        end else begin
            state_r <= state_r;
            idx_r   <= idx_r;
            acc_r   <= acc_r;
        end
    end

    stream_output_register #(
        .DATA_WIDTH(REG_WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_s),
        .load_data (load_word_s),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (held_word_s)
    );

    assign out_data    = held_word_s[WORD_WIDTH-1:0];
    assign out_last    = held_word_s[WORD_WIDTH];
    assign out_count   = held_word_s[REG_WIDTH-1 -: COUNT_WIDTH];
    assign frames_done = frames_done_r;

endmodule

// File: tb/tb_byte_stream_packer.sv
// Directed table-driven bench for byte_stream_packer with REPLICATION_FACTOR = 3.
module tb_byte_stream_packer;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [23:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [1:0]  out_count;
    logic [15:0] frames_done;

    int total;
    int bad;

    byte_stream_packer #(.REPLICATION_FACTOR(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_last     (in_last),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .out_count   (out_count),
        .frames_done (frames_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic        ordy;
        logic        e_rdy;
        logic        e_ov;
        logic [23:0] e_data;
        logic [1:0]  e_cnt;
        logic        e_last;
        logic [15:0] e_fd;
    } vec_t;

    vec_t vecs[27];

    function automatic vec_t mk(logic v, logic [7:0] d, logic l, logic ordy, logic e_rdy,
                                logic e_ov, logic [23:0] e_data, logic [1:0] e_cnt,
                                logic e_last, logic [15:0] e_fd);
        vec_t t;
        t.v = v; t.d = d; t.l = l; t.ordy = ordy; t.e_rdy = e_rdy; t.e_ov = e_ov;
        t.e_data = e_data; t.e_cnt = e_cnt; t.e_last = e_last; t.e_fd = e_fd;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive inputs on the falling edge; outputs are then sampled 1 time unit later.
    task automatic drive(input logic v, input logic [7:0] d, input logic l,
                         input logic en, input logic ordy);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        enable    = en;
        out_ready = ordy;
        #1;
    endtask

    task automatic check_word(input string tag, input logic [23:0] d,
                              input logic [1:0] c, input logic l);
        check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".out_data"},  {8'd0, out_data},   {8'd0, d});
        check({tag, ".out_count"}, {30'd0, out_count}, {30'd0, c});
        check({tag, ".out_last"},  {31'd0, out_last},  {31'd0, l});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        enable = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b1;

        //        v     d     l     ordy  rdy   ov    data        cnt   last  fd
        vecs[0]  = mk(1'b1, 8'h41, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000, 2'd0, 1'b0, 16'd0);
        vecs[1]  = mk(1'b1, 8'h42, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000, 2'd0, 1'b0, 16'd0);
        vecs[2]  = mk(1'b1, 8'h43, 1'b1, 1'b1, 1'b1, 1'b0, 24'h000000, 2'd0, 1'b0, 16'd0);
        vecs[3]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 24'h434241, 2'd3, 1'b1, 16'd1);
        vecs[4]  = mk(1'b1, 8'h41, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000, 2'd0, 1'b0, 16'd1);
        vecs[5]  = mk(1'b1, 8'h42, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000, 2'd0, 1'b0, 16'd1);
        vecs[6]  = mk(1'b1, 8'h43, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000, 2'd0, 1'b0, 16'd1);
        vecs[7]  = mk(1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 1'b1, 24'h434241, 2'd3, 1'b0, 16'd1);
        vecs[8]  = mk(1'b1, 8'h45, 1'b1, 1'b1, 1'b1, 1'b0, 24'h000000, 2'd0, 1'b0, 16'd1);
        vecs[9]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 24'h004544, 2'd2, 1'b1, 16'd2);
        vecs[10] = mk(1'b1, 8'h7F, 1'b1, 1'b1, 1'b1, 1'b0, 24'h000000, 2'd0, 1'b0, 16'd2);
        vecs[11] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 24'h00007F, 2'd1, 1'b1, 16'd3);
        vecs[12] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000, 2'd0, 1'b0, 16'd3);
        vecs[13] = mk(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000, 2'd0, 1'b0, 16'd3);
        vecs[14] = mk(1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000, 2'd0, 1'b0, 16'd3);
        vecs[15] = mk(1'b1, 8'h13, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000, 2'd0, 1'b0, 16'd3);
        vecs[16] = mk(1'b1, 8'h14, 1'b0, 1'b0, 1'b0, 1'b1, 24'h131211, 2'd3, 1'b0, 16'd3);
        vecs[17] = mk(1'b1, 8'h14, 1'b0, 1'b0, 1'b0, 1'b1, 24'h131211, 2'd3, 1'b0, 16'd3);
        vecs[18] = mk(1'b1, 8'h14, 1'b0, 1'b1, 1'b1, 1'b1, 24'h131211, 2'd3, 1'b0, 16'd3);
        vecs[19] = mk(1'b1, 8'h15, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000, 2'd0, 1'b0, 16'd3);
        vecs[20] = mk(1'b1, 8'h16, 1'b1, 1'b1, 1'b1, 1'b0, 24'h000000, 2'd0, 1'b0, 16'd3);
        vecs[21] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 24'h161514, 2'd3, 1'b1, 16'd4);
        vecs[22] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 24'h161514, 2'd3, 1'b1, 16'd4);
        vecs[23] = mk(1'b1, 8'h31, 1'b1, 1'b1, 1'b1, 1'b0, 24'h000000, 2'd0, 1'b0, 16'd4);
        vecs[24] = mk(1'b1, 8'h32, 1'b1, 1'b1, 1'b1, 1'b1, 24'h000031, 2'd1, 1'b1, 16'd5);
        vecs[25] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 24'h000032, 2'd1, 1'b1, 16'd6);
        vecs[26] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000, 2'd0, 1'b0, 16'd6);

        // Reset state, with enable high to show in_ready is still held low.
        repeat (2) @(negedge clk);
        #1;
        check("rst.in_ready",    {31'd0, in_ready},  32'd0);
        check("rst.out_valid",   {31'd0, out_valid}, 32'd0);
        check("rst.out_data",    {8'd0, out_data},   32'd0);
        check("rst.out_count",   {30'd0, out_count}, 32'd0);
        check("rst.out_last",    {31'd0, out_last},  32'd0);
        check("rst.frames_done", {16'd0, frames_done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].l, 1'b1, vecs[i].ordy);
            check($sformatf("vec%0d.in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].e_rdy});
            check($sformatf("vec%0d.frames_done", i), {16'd0, frames_done}, {16'd0, vecs[i].e_fd});
            if (vecs[i].e_ov) begin
                check_word($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_cnt, vecs[i].e_last);
            end else begin
                check($sformatf("vec%0d.out_valid", i), {31'd0, out_valid}, 32'd0);
            end
        end

        // Enable dropped mid-frame: partial word must survive the pause.
        drive(1'b1, 8'h41, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 8'h42, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 8'h99, 1'b1, 1'b0, 1'b1);
            check($sformatf("en_low%0d.in_ready", k), {31'd0, in_ready}, 32'd0);
            check($sformatf("en_low%0d.out_valid", k), {31'd0, out_valid}, 32'd0);
        end
        drive(1'b1, 8'h43, 1'b1, 1'b1, 1'b1);
        check("en_resume.in_ready", {31'd0, in_ready}, 32'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        check_word("en_resume", 24'h434241, 2'd3, 1'b1);
        check("en_resume.frames_done", {16'd0, frames_done}, 32'd7);

        // Reset mid-frame discards the partial word and the counter.
        drive(1'b1, 8'hA1, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 8'hA2, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst.out_valid",   {31'd0, out_valid},   32'd0);
        check("midrst.frames_done", {16'd0, frames_done}, 32'd0);
        check("midrst.in_ready",    {31'd0, in_ready},    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 8'h01, 1'b0, 1'b1, 1'b1);
        check("postrst.out_valid", {31'd0, out_valid}, 32'd0);
        drive(1'b1, 8'h02, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        check_word("postrst", 24'h030201, 2'd3, 1'b1);
        check("postrst.frames_done", {16'd0, frames_done}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
